// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between a datapath (master) and the
//   mem_responder byte memory (slave). Clock and reset are not part of the
//   bundle; they stay plain ports on the modules.
//
//   Enable   master -> slave  request strobe, held high until MFC is seen
//   OpCode   master -> slave  SPARC op3 access type
//   Address  master -> slave  byte address (MAR value)
//   DataIn   master -> slave  store data (MDR value), right-justified
//   DataOut  slave  -> master load result, right-justified, registered
//   MFC      slave  -> master memory-function-complete, registered
//   MSET     slave  -> master access error flag, valid while MFC=1
interface mem_responder_if;
   logic        Enable;
   logic [5:0]  OpCode;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MFC;
   logic        MSET;

   modport master (
      output Enable, OpCode, Address, DataIn,
      input  DataOut, MFC, MSET
   );

   modport slave (
      input  Enable, OpCode, Address, DataIn,
      output DataOut, MFC, MSET
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   512x8 big-endian byte memory answering SPARC-style load/store requests
//   with a fixed, parameterised wait time and an MFC handshake.
//
//   Parameters
//     LATENCY  wait cycles between request capture and access (0..15)
//   Ports
//     Clk      single clock, all state changes on its rising edge
//     Clr      asynchronous active-low reset (memory contents untouched)
//     bus      mem_responder_if.slave: Enable/OpCode/Address/DataIn in,
//              DataOut/MFC/MSET out
module mem_responder #(
   parameter int unsigned LATENCY = 2
) (
   input  logic           Clk,
   input  logic           Clr,
   mem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   localparam logic [5:0] OP_LD   = 6'b000000;
   localparam logic [5:0] OP_LDUB = 6'b000001;
   localparam logic [5:0] OP_LDUH = 6'b000010;
   localparam logic [5:0] OP_LDSB = 6'b001001;
   localparam logic [5:0] OP_LDSH = 6'b001010;
   localparam logic [5:0] OP_ST   = 6'b000100;
   localparam logic [5:0] OP_STB  = 6'b000101;
   localparam logic [5:0] OP_STH  = 6'b000110;

   localparam logic [3:0] WAIT_INIT = 4'(LATENCY);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] dout_q, dout_d;
   logic        mfc_q, mfc_d;
   logic        mset_q, mset_d;
   logic        we;

   logic [7:0]  mem [0:511];

   // Access decode, driven purely from the captured request
   logic        is_load, is_store, is_signed, op_ok, misaligned, access_err;
   size_t       size;
   logic [8:0]  idx;
   logic [31:0] rd_word, rd_val;
   logic [15:0] rd_half;
   logic [7:0]  rd_byte;

   assign idx = addr_q[8:0];

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_signed = 1'b0;
      op_ok     = 1'b1;
      size      = SZ_BYTE;
      case (op_q)
         OP_LD:   begin is_load  = 1'b1; size = SZ_WORD; end
         OP_LDUB: begin is_load  = 1'b1; size = SZ_BYTE; end
         OP_LDUH: begin is_load  = 1'b1; size = SZ_HALF; end
         OP_LDSB: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
         OP_LDSH: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
         OP_ST:   begin is_store = 1'b1; size = SZ_WORD; end
         OP_STB:  begin is_store = 1'b1; size = SZ_BYTE; end
         OP_STH:  begin is_store = 1'b1; size = SZ_HALF; end
         default: op_ok = 1'b0;
      endcase

      case (size)
         SZ_WORD: misaligned = |addr_q[1:0];
         SZ_HALF: misaligned = addr_q[0];
         default: misaligned = 1'b0;
      endcase

      access_err = !op_ok || (|addr_q[31:9]) || misaligned;
   end

   // Read the whole containing word, then narrow; byte 0 of the word is the
   // most significant (big-endian).
   always_comb begin
      rd_word = {mem[{idx[8:2], 2'b00}], mem[{idx[8:2], 2'b01}],
                 mem[{idx[8:2], 2'b10}], mem[{idx[8:2], 2'b11}]};
      rd_half = idx[1] ? rd_word[15:0] : rd_word[31:16];
      case (idx[1:0])
         2'd0:    rd_byte = rd_word[31:24];
         2'd1:    rd_byte = rd_word[23:16];
         2'd2:    rd_byte = rd_word[15:8];
         default: rd_byte = rd_word[7:0];
      endcase
      case (size)
         SZ_WORD: rd_val = rd_word;
         SZ_HALF: rd_val = {{16{is_signed & rd_half[15]}}, rd_half};
         default: rd_val = {{24{is_signed & rd_byte[7]}}, rd_byte};
      endcase
   end

   // Next-state / next-register logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      mfc_d   = mfc_q;
      mset_d  = mset_q;
      we      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.Enable) begin
               op_d    = bus.OpCode;
               addr_d  = bus.Address;
               wdata_d = bus.DataIn;
               cnt_d   = WAIT_INIT;
               state_d = BUSY;
            end
         end

         BUSY: begin
            // A dropped strobe wins over a counter that has just expired,
            // so an abandoned store never reaches the array.
            if (!bus.Enable) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               we      = is_store && !access_err;
               dout_d  = (is_load && !access_err) ? rd_val : '0;
               mset_d  = access_err;
               mfc_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         DONE: begin
            if (!bus.Enable) begin
               mfc_d   = 1'b0;
               mset_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         mfc_q   <= 1'b0;
         mset_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         mfc_q   <= mfc_d;
         mset_q  <= mset_d;
      end
   end

   // Array has no reset; a reset in BUSY forces IDLE at once, so we is low.
   always_ff @(posedge Clk) begin
      if (we) begin
         case (size)
            SZ_WORD: begin
               mem[{idx[8:2], 2'b00}] <= wdata_q[31:24];
               mem[{idx[8:2], 2'b01}] <= wdata_q[23:16];
               mem[{idx[8:2], 2'b10}] <= wdata_q[15:8];
               mem[{idx[8:2], 2'b11}] <= wdata_q[7:0];
            end
            SZ_HALF: begin
               mem[{idx[8:1], 1'b0}] <= wdata_q[15:8];
               mem[{idx[8:1], 1'b1}] <= wdata_q[7:0];
            end
            default: mem[idx] <= wdata_q[7:0];
         endcase
      end
   end

   assign bus.DataOut = dout_q;
   assign bus.MFC     = mfc_q;
   assign bus.MSET    = mset_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Self-checking bench for mem_responder. Two instances share one request
//   stream: the main one with LATENCY=2 and a second built with LATENCY=0.
//   Directed table, hand-written abort/reset/hold sequences, then random
//   traffic checked against a byte-array reference model.
module tb_mem_responder;

   localparam int unsigned LAT = 2;

   localparam logic [5:0] LD   = 6'b000000;
   localparam logic [5:0] LDUB = 6'b000001;
   localparam logic [5:0] LDUH = 6'b000010;
   localparam logic [5:0] LDSB = 6'b001001;
   localparam logic [5:0] LDSH = 6'b001010;
   localparam logic [5:0] ST   = 6'b000100;
   localparam logic [5:0] STB  = 6'b000101;
   localparam logic [5:0] STH  = 6'b000110;

   logic        Clk = 1'b0;
   logic        Clr = 1'b0;
   logic        en;
   logic [5:0]  op;
   logic [31:0] addr, din;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [7:0] ref_mem [512];

   mem_responder_if bus ();
   mem_responder_if bus0 ();

   assign bus.Enable   = en;
   assign bus.OpCode   = op;
   assign bus.Address  = addr;
   assign bus.DataIn   = din;
   assign bus0.Enable  = en;
   assign bus0.OpCode  = op;
   assign bus0.Address = addr;
   assign bus0.DataIn  = din;

   mem_responder #(.LATENCY(LAT)) dut  (.Clk(Clk), .Clr(Clr), .bus(bus));
   mem_responder #(.LATENCY(0))   dut0 (.Clk(Clk), .Clr(Clr), .bus(bus0));

   always #5 Clk = ~Clk;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp_dout;
      logic        exp_mset;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One full request: capture, wait for MFC, optionally hold in DONE,
   // then release and confirm the handshake closes.
   task automatic do_req(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                         input int unsigned hold, input logic [31:0] ed, input logic ee,
                         input bit chk0);
      int unsigned n, n0;
      @(negedge Clk);
      en = 1'b1; op = o; addr = a; din = d;
      n = 0; n0 = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #1;
         n++;
         if (n == 1) begin
            op   = 6'($urandom);
            addr = $urandom;
            din  = $urandom;
         end
         if (n0 == 0 && bus0.MFC) n0 = n;
         if (bus.MFC) break;
      end
      check("latency", n, LAT + 2);
      check("latency_lat0", n0, 2);
      check("dout", bus.DataOut, ed);
      check("mset", {31'b0, bus.MSET}, {31'b0, ee});
      if (chk0) begin
         check("dout_lat0", bus0.DataOut, ed);
         check("mset_lat0", {31'b0, bus0.MSET}, {31'b0, ee});
      end
      for (int h = 0; h < int'(hold); h++) begin
         @(posedge Clk); #1;
         check("hold_mfc", {31'b0, bus.MFC}, 32'd1);
         check("hold_dout", bus.DataOut, ed);
      end
      en = 1'b0;
      @(posedge Clk); #1;
      check("release_mfc", {31'b0, bus.MFC}, 32'd0);
      check("release_mset", {31'b0, bus.MSET}, 32'd0);
      check("release_dout", bus.DataOut, ed);
   endtask

   // Reference model: size/sign from the opcode, bytes assembled MSB-first.
   task automatic model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err);
      int unsigned sz;
      bit ld, sgn, ok;
      ok = 1; ld = 0; sgn = 0; sz = 1;
      case (o)
         LD:   begin ld = 1; sz = 4; end
         LDUB: begin ld = 1; sz = 1; end
         LDUH: begin ld = 1; sz = 2; end
         LDSB: begin ld = 1; sgn = 1; sz = 1; end
         LDSH: begin ld = 1; sgn = 1; sz = 2; end
         ST:   sz = 4;
         STB:  sz = 1;
         STH:  sz = 2;
         default: ok = 0;
      endcase
      err = !ok || (a >= 32'd512) || ((a % sz) != 0);
      rd  = '0;
      if (!err) begin
         if (ld) begin
            for (int i = 0; i < int'(sz); i++) rd = (rd << 8) | 32'(ref_mem[int'(a) + i]);
            if (sgn && rd[8*sz-1]) rd = rd | (32'hFFFF_FFFF << (8*sz));
         end else begin
            for (int i = 0; i < int'(sz); i++)
               ref_mem[int'(a) + i] = 8'(d >> (8*(int'(sz) - 1 - i)));
         end
      end
   endtask

   initial begin
      vec_t vecs[$];
      logic [5:0]  ops [8];
      logic [31:0] e_d, r_a, r_d;
      logic [5:0]  r_o;
      logic        e_m;
      bit          seen;

      ops = '{LD, LDUB, LDUH, LDSB, LDSH, ST, STB, STH};

      vecs = '{
         '{ST,    32'h010, 32'hDEADBEEF, 32'h0,        1'b0},
         '{LD,    32'h010, 32'h0,        32'hDEADBEEF, 1'b0},
         '{LDSB,  32'h010, 32'h0,        32'hFFFFFFDE, 1'b0},
         '{LDUB,  32'h011, 32'h0,        32'h000000AD, 1'b0},
         '{LDSH,  32'h012, 32'h0,        32'hFFFFBEEF, 1'b0},
         '{LDUH,  32'h012, 32'h0,        32'h0000BEEF, 1'b0},
         '{STB,   32'h013, 32'h12345677, 32'h0,        1'b0},
         '{LD,    32'h010, 32'h0,        32'hDEADBE77, 1'b0},
         '{STH,   32'h010, 32'h0000CAFE, 32'h0,        1'b0},
         '{LD,    32'h010, 32'h0,        32'hCAFEBE77, 1'b0},
         '{LD,    32'h011, 32'h0,        32'h0,        1'b1},
         '{STH,   32'h001, 32'h0000BBBB, 32'h0,        1'b1},
         '{LD,    32'h200, 32'h0,        32'h0,        1'b1},
         '{6'h3F, 32'h010, 32'h55555555, 32'h0,        1'b1},
         '{ST,    32'h012, 32'h99999999, 32'h0,        1'b1},
         '{STB,   32'h80000010, 32'h000000AA, 32'h0,   1'b1},
         '{LD,    32'h010, 32'h0,        32'hCAFEBE77, 1'b0},
         '{ST,    32'h020, 32'hA5A5A5A5, 32'h0,        1'b0}
      };

      // Reset state, observed while Clr is still low
      en = 1'b0; op = '0; addr = '0; din = '0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_mfc",  {31'b0, bus.MFC},  32'd0);
      check("reset_mset", {31'b0, bus.MSET}, 32'd0);
      check("reset_dout", bus.DataOut,       32'd0);
      check("reset_mfc_lat0", {31'b0, bus0.MFC}, 32'd0);
      @(negedge Clk);
      Clr = 1'b1;

      foreach (vecs[i])
         do_req(vecs[i].op, vecs[i].addr, vecs[i].din, 0, vecs[i].exp_dout, vecs[i].exp_mset, 1'b1);

      // Enable dropped after one BUSY cycle: abort, no write
      @(negedge Clk);
      en = 1'b1; op = ST; addr = 32'h020; din = 32'h11111111;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      en = 1'b0;
      seen = 0;
      repeat (6) begin @(posedge Clk); #1; seen |= bus.MFC; end
      check("abort_no_mfc", {31'b0, seen}, 32'd0);
      do_req(LD, 32'h020, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 1'b0);

      // Reset pulse during BUSY: immediate clear, no write
      @(negedge Clk);
      en = 1'b1; op = ST; addr = 32'h020; din = 32'h11111111;
      @(posedge Clk); #2;
      Clr = 1'b0; en = 1'b0;
      #1;
      check("clr_mfc",  {31'b0, bus.MFC},  32'd0);
      check("clr_mset", {31'b0, bus.MSET}, 32'd0);
      check("clr_dout", bus.DataOut,       32'd0);
      @(negedge Clk);
      Clr = 1'b1;
      seen = 0;
      repeat (6) begin @(posedge Clk); #1; seen |= bus.MFC; end
      check("clr_no_mfc", {31'b0, seen}, 32'd0);
      do_req(LD, 32'h020, 32'h0, 0, 32'hA5A5A5A5, 1'b0, 1'b0);

      // Held in DONE for 5 cycles
      do_req(LD, 32'h010, 32'h0, 5, 32'hCAFEBE77, 1'b0, 1'b0);

      // Random phase: fill the whole array, then mixed traffic
      for (int w = 0; w < 128; w++) begin
         r_d = $urandom;
         model(ST, 32'(w * 4), r_d, e_d, e_m);
         do_req(ST, 32'(w * 4), r_d, 0, e_d, e_m, 1'b0);
      end
      for (int t = 0; t < 150; t++) begin
         r_o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
         r_a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
         r_d = $urandom;
         model(r_o, r_a, r_d, e_d, e_m);
         do_req(r_o, r_a, r_d, $urandom_range(0, 3), e_d, e_m, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
